regfile_write_arbiter: RTL

- Shares the register file's single write port between two writeback requesters:
  - port A: in-order pipeline writeback, latency-critical.
  - port B: long-latency unit (multiply/divide or load return), buffered in a small FIFO.
- Fixed priority to A, with a starvation limit that guarantees B forward progress.
- Drives the register file write port (we / write register / write data) combinationally within the cycle; the register file captures on the falling edge of the same cycle.

---
 rtl/regfile_write_arbiter.sv | 94 +++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between pipeline writeback (A, priority)
// and a FIFO-buffered long-latency requester (B) with a starvation bound for B.
module regfile_write_arbiter #(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic [4:0]                 a_reg,
  input  logic [31:0]                a_data,
  input  logic                       b_valid,
  output logic                       b_ready,
  input  logic [4:0]                 b_reg,
  input  logic [31:0]                b_data,
  output logic                       rf_we,
  output logic [4:0]                 rf_wreg,
  output logic [31:0]                rf_wdata,
  output logic                       grant_b,
  output logic [$clog2(DEPTH):0]     b_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    mem_reg  [DEPTH];
  logic [31:0]   mem_data [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] starve_cnt;

  logic nonempty;
  logic starved;
  logic a_win;
  logic b_win;
  logic push;
  logic pop;

  // Arbitration and write-port drive; everything is forced quiet while in reset.
  always_comb begin
    nonempty = (count != CW'(0));
    starved  = nonempty && (starve_cnt == SW'(STARVE_LIMIT));
    a_ready  = !rst && !starved;
    b_ready  = !rst && (count != CW'(DEPTH));
    a_win    = !rst && a_valid && !starved;
    b_win    = !rst && !a_win && nonempty;
    push     = b_valid && b_ready;
    pop      = b_win;
    grant_b  = b_win;
    rf_wreg  = 5'd0;
    rf_wdata = 32'd0;
    if (a_win) begin
      rf_wreg  = a_reg;
      rf_wdata = a_data;
    end else if (b_win) begin
      rf_wreg  = mem_reg[rd_ptr];
      rf_wdata = mem_data[rd_ptr];
    end
    rf_we   = (a_win || b_win) && (rf_wreg != 5'd0);
    b_count = count;
  end

  // FIFO pointers, occupancy and starvation counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (nonempty && a_win) begin
        if (starve_cnt != SW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + SW'(1);
      end else begin
        starve_cnt <= '0;
      end
    end
  end

  // Payload storage needs no reset: entries are only read while occupied.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_ptr]  <= b_reg;
      mem_data[wr_ptr] <= b_data;
    end
  end

endmodule
